// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared width defaults and FSM state type for mem_burst_arbiter
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 24;
  localparam int DEF_LEN_W = 10;
  localparam int DEF_DATA_W = 64;
  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first requesting slot strictly after last
// ports: req (slot request vector), last (previously granted slot), found (any request), slot (winner)
module rr_picker #(
  parameter int N = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  output logic          found,
  output logic [SW-1:0] slot
);
  logic [SW-1:0] idx;
  always_comb begin
    found = 1'b0;
    slot = '0;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      idx = SW'((int'(last) + i) % N);
      if (req[idx]) begin
        found = 1'b1;
        slot = idx;
      end
    end
  end
endmodule

// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: round-robin share of one DDR2 burst engine between NCH write/read channel pairs
// ports: mem_clk/rst_n; ch_* per-channel request/len/addr/data and routed strobes/finish pulses;
//        wr_burst_*/rd_burst_* toward the engine; grant_slot/busy status; timeout_err sticky watchdog flag
module mem_burst_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NCH = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT = 4096
) (
  input  logic                        mem_clk,
  input  logic                        rst_n,
  input  logic [NCH-1:0]              ch_wr_req,
  input  logic [NCH*LEN_W-1:0]        ch_wr_len,
  input  logic [NCH*ADDR_W-1:0]       ch_wr_addr,
  input  logic [NCH*DATA_W-1:0]       ch_wr_data,
  output logic [NCH-1:0]              ch_wr_data_req,
  output logic [NCH-1:0]              ch_wr_finish,
  input  logic [NCH-1:0]              ch_rd_req,
  input  logic [NCH*LEN_W-1:0]        ch_rd_len,
  input  logic [NCH*ADDR_W-1:0]       ch_rd_addr,
  output logic [DATA_W-1:0]           ch_rd_data,
  output logic [NCH-1:0]              ch_rd_data_valid,
  output logic [NCH-1:0]              ch_rd_finish,
  output logic                        wr_burst_req,
  output logic [LEN_W-1:0]            wr_burst_len,
  output logic [ADDR_W-1:0]           wr_burst_addr,
  output logic [DATA_W-1:0]           wr_burst_data,
  input  logic                        wr_burst_data_req,
  input  logic                        wr_burst_finish,
  output logic                        rd_burst_req,
  output logic [LEN_W-1:0]            rd_burst_len,
  output logic [ADDR_W-1:0]           rd_burst_addr,
  input  logic                        rd_burst_data_valid,
  input  logic [DATA_W-1:0]           rd_burst_data,
  input  logic                        rd_burst_finish,
  output logic [$clog2(2*NCH)-1:0]    grant_slot,
  output logic                        busy,
  output logic                        timeout_err
);
  localparam int N = 2 * NCH;
  localparam int SW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [N-1:0] req;
  logic [SW-1:0] last_slot, pick, pick_ch, g_ch;
  logic found, g_rd, done;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addr, pick_addr;
  logic [LEN_W-1:0] len, pick_len;
  for (genvar k = 0; k < NCH; k++) begin : g_slot
    assign req[2*k] = ch_wr_req[k];
    assign req[2*k+1] = ch_rd_req[k];
  end
  rr_picker #(.N(N), .SW(SW)) u_pick (
    .req(req),
    .last(last_slot),
    .found(found),
    .slot(pick)
  );
  // odd slots are reads; slot >> 1 is the owning channel
  assign pick_ch = pick >> 1;
  assign g_ch = grant_slot >> 1;
  assign g_rd = grant_slot[0];
  assign pick_addr = pick[0] ? ch_rd_addr[pick_ch*ADDR_W +: ADDR_W] : ch_wr_addr[pick_ch*ADDR_W +: ADDR_W];
  assign pick_len = pick[0] ? ch_rd_len[pick_ch*LEN_W +: LEN_W] : ch_wr_len[pick_ch*LEN_W +: LEN_W];
  // one latched address/length serves whichever direction is granted
  assign wr_burst_addr = addr;
  assign rd_burst_addr = addr;
  assign wr_burst_len = len;
  assign rd_burst_len = len;
  assign wr_burst_data = ch_wr_data[g_ch*DATA_W +: DATA_W];
  assign ch_rd_data = rd_burst_data;
  assign ch_wr_data_req = (busy && !g_rd && wr_burst_data_req) ? NCH'(1) << g_ch : '0;
  assign ch_rd_data_valid = (busy && g_rd && rd_burst_data_valid) ? NCH'(1) << g_ch : '0;
  // a finish on the other direction is ignored
  assign done = g_rd ? rd_burst_finish : wr_burst_finish;
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_slot <= SW'(N - 1);
      grant_slot <= '0;
      busy <= 1'b0;
      cnt <= '0;
      addr <= '0;
      len <= '0;
      wr_burst_req <= 1'b0;
      rd_burst_req <= 1'b0;
      ch_wr_finish <= '0;
      ch_rd_finish <= '0;
      timeout_err <= 1'b0;
    end else begin
      ch_wr_finish <= '0;
      ch_rd_finish <= '0;
      case (state)
        IDLE: if (found) begin
          state <= BURST;
          grant_slot <= pick;
          last_slot <= pick;
          addr <= pick_addr;
          len <= pick_len;
          busy <= 1'b1;
          cnt <= '0;
          wr_burst_req <= !pick[0];
          rd_burst_req <= pick[0];
        end
        BURST: if (done) begin
          state <= GAP;
          busy <= 1'b0;
          wr_burst_req <= 1'b0;
          rd_burst_req <= 1'b0;
          ch_wr_finish <= g_rd ? '0 : NCH'(1) << g_ch;
          ch_rd_finish <= g_rd ? NCH'(1) << g_ch : '0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          // watchdog: abandon the burst silently and flag it
          state <= GAP;
          busy <= 1'b0;
          wr_burst_req <= 1'b0;
          rd_burst_req <= 1'b0;
          timeout_err <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb_mem_burst_arbiter: table-driven, hand-sequenced and randomized checks of mem_burst_arbiter
module tb_mem_burst_arbiter;
  logic mem_clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] ch_wr_req = '0, ch_rd_req = '0;
  logic [19:0] ch_wr_len = {10'd17, 10'd480};
  logic [47:0] ch_wr_addr = {24'h123456, 24'h000100};
  logic [127:0] ch_wr_data = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
  logic [19:0] ch_rd_len = {10'd1023, 10'd64};
  logic [47:0] ch_rd_addr = {24'h3FFFF0, 24'h0A0000};
  logic [1:0] ch_wr_data_req, ch_wr_finish, ch_rd_data_valid, ch_rd_finish;
  logic [63:0] ch_rd_data, wr_burst_data;
  logic wr_burst_req, rd_burst_req, busy, timeout_err;
  logic [9:0] wr_burst_len, rd_burst_len;
  logic [23:0] wr_burst_addr, rd_burst_addr;
  logic wr_burst_data_req = 0, wr_burst_finish = 0, rd_burst_data_valid = 0, rd_burst_finish = 0;
  logic [63:0] rd_burst_data = '0;
  logic [1:0] grant_slot;
  int n_cmp = 0, n_err = 0, model_last = 3;
  typedef struct {logic [1:0] wr; logic [1:0] rd; logic [1:0] exp;} vec_t;
  vec_t tbl[10];

  mem_burst_arbiter #(.NCH(2), .TIMEOUT(16)) dut (
    .mem_clk(mem_clk), .rst_n(rst_n),
    .ch_wr_req(ch_wr_req), .ch_wr_len(ch_wr_len), .ch_wr_addr(ch_wr_addr), .ch_wr_data(ch_wr_data),
    .ch_wr_data_req(ch_wr_data_req), .ch_wr_finish(ch_wr_finish),
    .ch_rd_req(ch_rd_req), .ch_rd_len(ch_rd_len), .ch_rd_addr(ch_rd_addr),
    .ch_rd_data(ch_rd_data), .ch_rd_data_valid(ch_rd_data_valid), .ch_rd_finish(ch_rd_finish),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data(wr_burst_data), .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish),
    .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data), .rd_burst_finish(rd_burst_finish),
    .grant_slot(grant_slot), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_addr(input logic [1:0] s);
    return s == 0 ? 24'h000100 : s == 1 ? 24'h0A0000 : s == 2 ? 24'h123456 : 24'h3FFFF0;
  endfunction

  function automatic logic [9:0] exp_len(input logic [1:0] s);
    return s == 0 ? 10'd480 : s == 1 ? 10'd64 : s == 2 ? 10'd17 : 10'd1023;
  endfunction

  // reference: first requesting slot in cyclic order after the last grant
  function automatic logic [1:0] model_pick(input logic [1:0] wr, input logic [1:0] rd, input int last);
    logic [3:0] r;
    r = {rd[1], wr[1], rd[0], wr[0]};
    for (int d = 1; d <= 4; d++) if (r[(last + d) % 4]) return 2'((last + d) % 4);
    return 2'd0;
  endfunction

  task automatic run_txn(input logic [1:0] wr, input logic [1:0] rd, input logic [1:0] exp, input int hold);
    int ch, w;
    logic isrd;
    ch = int'(exp) >> 1;
    isrd = exp[0];
    ch_wr_req = wr;
    ch_rd_req = rd;
    w = 0;
    do begin tick(); w++; end while (!busy && w < 20);
    chk("grant_lat", 64'(w), 64'd1);
    chk("grant_slot", grant_slot, exp);
    chk("burst_req", {wr_burst_req, rd_burst_req}, isrd ? 2'b01 : 2'b10);
    chk("burst_addr", isrd ? rd_burst_addr : wr_burst_addr, exp_addr(exp));
    chk("burst_len", isrd ? rd_burst_len : wr_burst_len, exp_len(exp));
    for (int i = 0; i < hold; i++) begin
      wr_burst_data_req = 1'($urandom);
      rd_burst_data_valid = 1'($urandom);
      rd_burst_data = {$urandom, $urandom};
      #1;
      chk("wr_dreq", ch_wr_data_req, (wr_burst_data_req && !isrd) ? 2'(1 << ch) : 2'b00);
      chk("rd_dval", ch_rd_data_valid, (rd_burst_data_valid && isrd) ? 2'(1 << ch) : 2'b00);
      chk("rd_data", ch_rd_data, rd_burst_data);
      if (!isrd) chk("wr_data", wr_burst_data, ch_wr_data[ch*64 +: 64]);
      tick();
    end
    wr_burst_data_req = 0;
    rd_burst_data_valid = 0;
    if (isrd) rd_burst_finish = 1; else wr_burst_finish = 1;
    tick();
    wr_burst_finish = 0;
    rd_burst_finish = 0;
    chk("fin_pulse", {ch_wr_finish, ch_rd_finish}, isrd ? {2'b00, 2'(1 << ch)} : {2'(1 << ch), 2'b00});
    chk("fin_busy", {busy, wr_burst_req, rd_burst_req}, 3'b000);
    ch_wr_req = 0;
    ch_rd_req = 0;
    tick();
    chk("fin_clear", {ch_wr_finish, ch_rd_finish}, 4'b0000);
    tick();
    model_last = int'(exp);
  endtask

  initial begin
    int w, beats;
    logic [1:0] wr, rd;
    tbl[0] = '{2'b01, 2'b00, 2'd0};
    tbl[1] = '{2'b11, 2'b11, 2'd1};
    tbl[2] = '{2'b11, 2'b11, 2'd2};
    tbl[3] = '{2'b11, 2'b11, 2'd3};
    tbl[4] = '{2'b11, 2'b11, 2'd0};
    tbl[5] = '{2'b00, 2'b10, 2'd3};
    tbl[6] = '{2'b01, 2'b10, 2'd0};
    tbl[7] = '{2'b10, 2'b01, 2'd1};
    tbl[8] = '{2'b10, 2'b00, 2'd2};
    tbl[9] = '{2'b00, 2'b01, 2'd1};
    tick();
    tick();
    chk("rst_out", {busy, wr_burst_req, rd_burst_req, timeout_err, ch_wr_finish, ch_rd_finish}, 8'h00);
    chk("rst_slot", grant_slot, 2'd0);
    rst_n = 1;
    tick();
    chk("idle_busy", busy, 1'b0);
    for (int i = 0; i < 10; i++) run_txn(tbl[i].wr, tbl[i].rd, tbl[i].exp, 2);

    // ch1 read with four valid beats, plus a stray write-side finish that must be ignored
    ch_rd_req = 2'b10;
    tick();
    chk("rd1_slot", grant_slot, 2'd3);
    beats = 0;
    for (int i = 0; i < 6; i++) begin
      rd_burst_data_valid = (i != 2 && i != 4);
      rd_burst_data = 64'hA5A5_A5A5_A5A5_A500 + 64'(i);
      wr_burst_data_req = 1;
      #1;
      chk("rd1_dval", ch_rd_data_valid, rd_burst_data_valid ? 2'b10 : 2'b00);
      chk("rd1_data", ch_rd_data, 64'hA5A5_A5A5_A5A5_A500 + 64'(i));
      chk("rd1_wdreq", ch_wr_data_req, 2'b00);
      if (ch_rd_data_valid[1]) beats++;
      tick();
    end
    rd_burst_data_valid = 0;
    wr_burst_data_req = 0;
    chk("rd1_beats", 64'(beats), 64'd4);
    wr_burst_finish = 1;
    tick();
    wr_burst_finish = 0;
    chk("wrong_fin", {busy, rd_burst_req, ch_wr_finish, ch_rd_finish}, 6'b110000);
    rd_burst_finish = 1;
    tick();
    rd_burst_finish = 0;
    chk("rd1_fin", ch_rd_finish, 2'b10);
    ch_rd_req = 0;
    tick();
    tick();

    // ch0 write dropped mid-burst, ch1 requests arrive during the burst
    ch_wr_req = 2'b01;
    tick();
    chk("drop_slot", grant_slot, 2'd0);
    ch_wr_req = 2'b10;
    ch_rd_req = 2'b10;
    ch_wr_addr[23:0] = 24'hDEAD00;
    tick();
    chk("drop_busy", {busy, wr_burst_req}, 2'b11);
    chk("drop_addr", wr_burst_addr, 24'h000100);
    ch_wr_addr[23:0] = 24'h000100;
    wr_burst_finish = 1;
    tick();
    wr_burst_finish = 0;
    chk("drop_fin", ch_wr_finish, 2'b01);
    w = 0;
    do begin tick(); w++; end while (!busy && w < 10);
    chk("drop_gap", 64'(w), 64'd2);
    chk("drop_next", grant_slot, 2'd2);
    wr_burst_finish = 1;
    tick();
    wr_burst_finish = 0;
    chk("ch1w_fin", ch_wr_finish, 2'b10);
    ch_wr_req = 0;
    tick();
    tick();
    chk("ch1r_grant", {busy, rd_burst_req, grant_slot}, 4'b1111);
    rd_burst_finish = 1;
    tick();
    rd_burst_finish = 0;
    chk("ch1r_fin", ch_rd_finish, 2'b10);
    ch_rd_req = 0;
    tick();
    tick();

    // watchdog: engine never finishes a ch0 read
    ch_rd_req = 2'b01;
    tick();
    chk("to_slot", grant_slot, 2'd1);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("to_hold", {rd_burst_req, timeout_err}, 2'b10);
    end
    tick();
    chk("to_err", {timeout_err, rd_burst_req, busy, ch_rd_finish}, 5'b10000);
    tick();
    tick();
    chk("to_resume", {busy, timeout_err, grant_slot}, 4'b1101);
    rd_burst_finish = 1;
    tick();
    rd_burst_finish = 0;
    chk("to_fin", ch_rd_finish, 2'b01);
    ch_rd_req = 0;
    tick();
    tick();

    // asynchronous reset in the middle of a ch1 write burst
    ch_wr_req = 2'b10;
    tick();
    chk("ar_slot", {busy, grant_slot}, 3'b110);
    wr_burst_data_req = 1;
    #2;
    rst_n = 0;
    #1;
    chk("ar_out", {busy, wr_burst_req, rd_burst_req, timeout_err, ch_wr_data_req}, 6'b000000);
    chk("ar_gslot", grant_slot, 2'd0);
    wr_burst_data_req = 0;
    ch_wr_req = 2'b11;
    ch_rd_req = 2'b11;
    tick();
    tick();
    rst_n = 1;
    tick();
    chk("ar_first", {busy, wr_burst_req, grant_slot}, 4'b1100);
    wr_burst_finish = 1;
    tick();
    wr_burst_finish = 0;
    chk("ar_fin", ch_wr_finish, 2'b01);
    ch_wr_req = 0;
    ch_rd_req = 0;
    tick();
    tick();
    model_last = 0;

    for (int i = 0; i < 25; i++) begin
      wr = 2'($urandom);
      rd = 2'($urandom);
      if ((wr | rd) == 2'b00) wr = 2'b01;
      run_txn(wr, rd, model_pick(wr, rd, model_last), int'($urandom_range(0, 4)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
